pipeline_ctrl: RTL and testbench

- Central pipeline controller for the 5-stage rv32i core. It generates the per-stage `load` enables and bubble/flush requests consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- It freezes the whole pipeline while instruction or data memory responses are outstanding.
- It inserts load-use bubbles and squashes wrong-path instructions on EX-stage redirects.

---
 rtl/pipeline_ctrl_pkg.sv | 47 ++++
 rtl/pipeline_ctrl_if.sv | 40 ++++
 rtl/pipeline_ctrl_hazard_detect.sv | 26 ++
 rtl/pipeline_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the rv32i pipeline controller: FSM states, the NOP control
// word injected on bubbles, and the bundled stage-enable output word.
package pipeline_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } pipe_ctrl_state_t;

  // Control word carried by ID/EX; an all-zero word performs no architectural update.
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
  } ctrl_word_t;

  localparam ctrl_word_t NOP_CTRL = '0;

  typedef struct packed {
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic bubble_if_id;
    logic bubble_id_ex;
  } pipe_ctrl_out_t;

  localparam pipe_ctrl_out_t CTRL_FROZEN = '0;

  function automatic pipe_ctrl_out_t ctrl_normal();
    pipe_ctrl_out_t c;
    c              = '0;
    c.load_pc      = 1'b1;
    c.load_if_id   = 1'b1;
    c.load_id_ex   = 1'b1;
    c.load_ex_mem  = 1'b1;
    c.load_mem_wb  = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake and stage-enable bundle between the datapath (master) and the
// pipeline controller (slave).
interface pipeline_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  imem_resp;
  logic                  dmem_req;
  logic                  dmem_resp;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic                  ex_dmem_read;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_redirect;

  logic load_pc;
  logic load_if_id;
  logic load_id_ex;
  logic load_ex_mem;
  logic load_mem_wb;
  logic bubble_if_id;
  logic bubble_id_ex;

  modport master (
    output imem_resp, dmem_req, dmem_resp,
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_dmem_read, ex_rd, ex_redirect,
    input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
    input  bubble_if_id, bubble_id_ex
  );

  modport slave (
    input  imem_resp, dmem_req, dmem_resp,
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_dmem_read, ex_rd, ex_redirect,
    output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
    output bubble_if_id, bubble_id_ex
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use detector: the load in ID/EX writes a register the
// instruction in IF/ID reads. x0 is never a hazard.
module hazard_detect #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_use_rs1,
  input  logic                  i_id_use_rs2,
  input  logic                  i_ex_dmem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  output logic                  o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_rd_live;

  always_comb begin
    w_rd_live  = (i_ex_rd != '0);
    w_rs1_hit  = i_id_use_rs1 & (i_id_rs1 == i_ex_rd);
    w_rs2_hit  = i_id_use_rs2 & (i_id_rs2 == i_ex_rd);
    o_load_use = i_ex_dmem_read & w_rd_live & (w_rs1_hit | w_rs2_hit);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: freezes all stages on outstanding memory responses,
// inserts load-use bubbles and squashes on EX redirects.
// Optional macro PIPE_CTRL_PERF_EN enables stall/bubble performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipeline_ctrl_if.slave   bus,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count
);

  pipe_ctrl_state_t r_state;
  pipe_ctrl_state_t w_state_nxt;
  logic             r_imem_done;
  logic             r_dmem_done;
  logic             w_imem_done_nxt;
  logic             w_dmem_done_nxt;
  logic             w_advance;
  logic             w_load_use;
  pipe_ctrl_out_t   w_out;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard (
    .i_id_rs1       (bus.id_rs1),
    .i_id_rs2       (bus.id_rs2),
    .i_id_use_rs1   (bus.id_use_rs1),
    .i_id_use_rs2   (bus.id_use_rs2),
    .i_ex_dmem_read (bus.ex_dmem_read),
    .i_ex_rd        (bus.ex_rd),
    .o_load_use     (w_load_use)
  );

  // A response pulse counts in the cycle it arrives, so advance is combinational.
  always_comb begin
    w_advance = (r_imem_done | bus.imem_resp) &
                (~bus.dmem_req | r_dmem_done | bus.dmem_resp);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= RUN;
      r_imem_done <= 1'b0;
      r_dmem_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_imem_done <= w_imem_done_nxt;
      r_dmem_done <= w_dmem_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_imem_done_nxt = r_imem_done;
    w_dmem_done_nxt = r_dmem_done;
    case (r_state)
      RUN: begin
        if (!w_advance) begin
          w_imem_done_nxt = r_imem_done | bus.imem_resp;
          w_dmem_done_nxt = r_dmem_done | bus.dmem_resp;
          w_state_nxt     = WAIT;
        end else begin
          w_imem_done_nxt = 1'b0;
          w_dmem_done_nxt = 1'b0;
        end
      end
      WAIT: begin
        if (w_advance) begin
          w_imem_done_nxt = 1'b0;
          w_dmem_done_nxt = 1'b0;
          w_state_nxt     = RUN;
        end else begin
          w_imem_done_nxt = r_imem_done | bus.imem_resp;
          w_dmem_done_nxt = r_dmem_done | bus.dmem_resp;
        end
      end
      default: begin
        w_state_nxt     = RUN;
        w_imem_done_nxt = 1'b0;
        w_dmem_done_nxt = 1'b0;
      end
    endcase
  end

  // Hazards are only acted on when the pipeline actually moves; while frozen the
  // IF/ID and ID/EX contents hold, so the same condition is seen on the advance cycle.
  always_comb begin
    w_out = CTRL_FROZEN;
    if (rst && w_advance) begin
      w_out = ctrl_normal();
      if (bus.ex_redirect) begin
        w_out.bubble_if_id = 1'b1;
        w_out.bubble_id_ex = 1'b1;
      end else if (w_load_use) begin
        w_out.load_pc      = 1'b0;
        w_out.load_if_id   = 1'b0;
        w_out.bubble_id_ex = 1'b1;
      end
    end
  end

  assign bus.load_pc      = w_out.load_pc;
  assign bus.load_if_id   = w_out.load_if_id;
  assign bus.load_id_ex   = w_out.load_id_ex;
  assign bus.load_ex_mem  = w_out.load_ex_mem;
  assign bus.load_mem_wb  = w_out.load_mem_wb;
  assign bus.bubble_if_id = w_out.bubble_if_id;
  assign bus.bubble_id_ex = w_out.bubble_id_ex;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_bubble_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cycles <= '0;
      r_bubble_count <= '0;
    end else begin
      if (!w_advance && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_out.bubble_id_ex && (r_bubble_count != '1)) begin
        r_bubble_count <= r_bubble_count + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign bubble_count = r_bubble_count;
`else
  assign stall_cycles = '0;
  assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: per-cycle check against a spec-level model
// plus hand-computed literal expectations for each vector.
module tb_pipeline_ctrl;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [6:0] FRZ  = 7'b00000_00;
  localparam logic [6:0] NORM = 7'b11111_00;
  localparam logic [6:0] LU   = 7'b00111_01;
  localparam logic [6:0] RDR  = 7'b11111_11;

  logic        clk;
  logic        rst;
  logic [31:0] stall_cycles;
  logic [31:0] bubble_count;
  int          errors = 0;
  int          checks = 0;
  bit          chk_en = 1'b0;

  // model state: responses already seen for the current pipeline step
  bit          m_imem_seen = 1'b0;
  bit          m_dmem_seen = 1'b0;
  longint      m_stalls    = 0;
  longint      m_bubbles   = 0;

  pipeline_ctrl_if #(.REG_ADDR_W(5)) bus ();

  pipeline_ctrl #(
    .REG_ADDR_W (5),
    .CNT_W      (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .stall_cycles (stall_cycles),
    .bubble_count (bubble_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [6:0] dut_vec;
  assign dut_vec = {bus.load_pc, bus.load_if_id, bus.load_id_ex, bus.load_ex_mem,
                    bus.load_mem_wb, bus.bubble_if_id, bus.bubble_id_ex};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit model_adv();
    return (m_imem_seen || bus.imem_resp) &&
           (!bus.dmem_req || m_dmem_seen || bus.dmem_resp);
  endfunction

  function automatic bit model_hazard();
    return bus.ex_dmem_read && (bus.ex_rd != 0) &&
           ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
            (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
  endfunction

  function automatic logic [6:0] model_vec();
    if (!rst || !model_adv()) return FRZ;
    if (bus.ex_redirect)      return RDR;
    if (model_hazard())       return LU;
    return NORM;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_imem_seen = 1'b0;
      m_dmem_seen = 1'b0;
      m_stalls    = 0;
      m_bubbles   = 0;
    end else if (!model_adv()) begin
      m_imem_seen = m_imem_seen || bus.imem_resp;
      m_dmem_seen = m_dmem_seen || bus.dmem_resp;
      m_stalls++;
    end else begin
      m_imem_seen = 1'b0;
      m_dmem_seen = 1'b0;
      if (bus.ex_redirect || model_hazard()) m_bubbles++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_outputs", {25'd0, dut_vec}, {25'd0, model_vec()});
      check("model_stall_cycles", stall_cycles, PERF ? 32'(m_stalls) : 32'd0);
      check("model_bubble_count", bubble_count, PERF ? 32'(m_bubbles) : 32'd0);
    end
  end

  task automatic cyc(input logic [6:0] exp, input string name);
    #2;
    check(name, {25'd0, dut_vec}, {25'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic set_hs(input logic imem, input logic dreq, input logic dresp, input logic redir);
    bus.imem_resp   = imem;
    bus.dmem_req    = dreq;
    bus.dmem_resp   = dresp;
    bus.ex_redirect = redir;
  endtask

  initial begin
    rst              = 1'b0;
    set_hs(1'b0, 1'b0, 1'b0, 1'b0);
    bus.id_rs1       = '0;
    bus.id_rs2       = '0;
    bus.id_use_rs1   = 1'b0;
    bus.id_use_rs2   = 1'b0;
    bus.ex_dmem_read = 1'b0;
    bus.ex_rd        = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    cyc(FRZ, "reset_idle0");
    set_hs(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(FRZ, "reset_with_imem");
    rst = 1'b1;
    check("stall_after_reset", stall_cycles, 32'd0);
    cyc(NORM, "run_stream0");
    cyc(NORM, "run_stream1");
    cyc(NORM, "run_stream2");
    rst = 1'b0;
    cyc(FRZ, "reset_midstream");
    rst = 1'b1;

    // data access: imem at cycle 0, dmem_resp at cycle 3
    set_hs(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(FRZ, "dmem_wait0");
    set_hs(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(FRZ, "dmem_wait1");
    cyc(FRZ, "dmem_wait2");
    set_hs(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(NORM, "dmem_advance");
    set_hs(1'b1, 1'b0, 1'b0, 1'b0);
    check("stall_cycles_3", stall_cycles, PERF ? 32'd3 : 32'd0);
    cyc(NORM, "dmem_back_to_run");

    // reverse order: dmem_resp at cycle 1, imem_resp at cycle 4
    set_hs(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(FRZ, "rev0");
    set_hs(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(FRZ, "rev1_dmem_only");
    set_hs(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(FRZ, "rev2");
    cyc(FRZ, "rev3");
    set_hs(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(NORM, "rev4_advance");
    cyc(FRZ, "rev_dmem_flag_cleared");
    set_hs(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(NORM, "rev_imem_flag_held");
    set_hs(1'b1, 1'b0, 1'b0, 1'b0);

    // load-use
    bus.ex_dmem_read = 1'b1;
    bus.ex_rd        = 5'd5;
    bus.id_rs1       = 5'd3;
    bus.id_use_rs1   = 1'b1;
    bus.id_rs2       = 5'd5;
    bus.id_use_rs2   = 1'b1;
    cyc(LU, "load_use_rs2");
    bus.ex_rd  = 5'd0;
    bus.id_rs1 = 5'd0;
    bus.id_rs2 = 5'd0;
    cyc(NORM, "rd_zero_no_stall");
    bus.ex_rd      = 5'd3;
    bus.id_rs1     = 5'd3;
    bus.id_use_rs1 = 1'b0;
    bus.id_rs2     = 5'd5;
    cyc(NORM, "rs1_not_used");
    bus.id_use_rs1 = 1'b1;
    cyc(LU, "load_use_rs1");
    bus.ex_redirect = 1'b1;
    cyc(RDR, "redirect_over_load_use");
    bus.ex_redirect  = 1'b0;
    bus.ex_dmem_read = 1'b0;
    check("bubble_count_3", bubble_count, PERF ? 32'd3 : 32'd0);
    cyc(NORM, "after_redirect");

    // redirect while frozen on dmem
    set_hs(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(FRZ, "redir_frozen0");
    set_hs(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(FRZ, "redir_frozen1");
    set_hs(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(RDR, "redir_advance");
    set_hs(1'b1, 1'b0, 1'b0, 1'b0);
    check("bubble_count_4", bubble_count, PERF ? 32'd4 : 32'd0);
    cyc(NORM, "redir_once");

    // reset while in WAIT discards the latched imem flag
    set_hs(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(FRZ, "enter_wait");
    rst = 1'b0;
    set_hs(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(FRZ, "reset_in_wait");
    rst = 1'b1;
    set_hs(1'b0, 1'b1, 1'b1, 1'b0);
    check("bubble_cleared", bubble_count, 32'd0);
    cyc(FRZ, "flags_discarded");
    set_hs(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(NORM, "recover");
    set_hs(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(NORM, "final_run");

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
